// File: rtl/sha_engine_arbiter_if.sv
// Signal bundle between hash clients, the arbiter and the shared sha_engine.
// The arbiter connects through the slave modport; the environment drives the master side.
interface sha_engine_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0][2:0]    req_mode;
    logic [NUM_REQ-1:0]         req_new_msg;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0][1023:0] req_msg;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic                       rsp_last;
    logic [511:0]               rsp_hash;
    logic                       eng_valid;
    logic                       eng_ready;
    logic [2:0]                 eng_mode;
    logic                       eng_new_msg;
    logic [1023:0]              eng_msg;
    logic [511:0]               eng_hash;

    modport slave (
        input  req_valid, req_mode, req_new_msg, req_last, req_msg, eng_ready, eng_hash,
        output req_ready, rsp_valid, rsp_last, rsp_hash, eng_valid, eng_mode, eng_new_msg,
               eng_msg
    );

    modport master (
        output req_valid, req_mode, req_new_msg, req_last, req_msg, eng_ready, eng_hash,
        input  req_ready, rsp_valid, rsp_last, rsp_hash, eng_valid, eng_mode, eng_new_msg,
               eng_msg
    );
endinterface

// File: rtl/sha_engine_arbiter.sv
// Round-robin, message-locked arbiter sharing one sha_engine among NUM_REQ clients.
// One block is in flight at a time: ARB -> ISSUE -> BUSY -> RESP -> ARB.
module sha_engine_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input logic               clk,
    input logic               rst,
    sha_engine_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [2:0]  MODE_SHA1 = 3'd0;

    typedef enum logic [1:0] {StArb, StIssue, StBusy, StResp} state_t;

    state_t             state_q, state_d;
    logic               locked_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [2:0]         mode_q;
    logic               new_msg_q;
    logic               last_q;
    logic [1023:0]      msg_q;
    logic               rsp_last_q;
    logic [511:0]       rsp_hash_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               accept;

    // While locked only the owner is considered, whatever its new_msg flag.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (locked_q) begin
            win_found = bus.req_valid[owner_q];
            win_idx   = owner_q;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
                if (!win_found && bus.req_valid[cand] && bus.req_new_msg[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    assign accept = (state_q == StArb) && win_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StArb;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArb:   if (win_found) state_d = StIssue;
            StIssue: state_d = StBusy;
            StBusy:  if (bus.eng_ready) state_d = StResp;
            StResp:  state_d = StArb;
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q   <= 1'b0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            mode_q     <= MODE_SHA1;
            new_msg_q  <= 1'b0;
            last_q     <= 1'b0;
            msg_q      <= '0;
            rsp_last_q <= 1'b0;
            rsp_hash_q <= '0;
        end else begin
            if (accept) begin
                msg_q     <= bus.req_msg[win_idx];
                new_msg_q <= bus.req_new_msg[win_idx];
                last_q    <= bus.req_last[win_idx];
                owner_q   <= win_idx;
                locked_q  <= 1'b1;
                // The engine keeps chaining state, so the mode belongs to the whole message.
                if (!locked_q) begin
                    mode_q <= bus.req_mode[win_idx];
                end
            end
            if ((state_q == StBusy) && bus.eng_ready) begin
                rsp_hash_q <= bus.eng_hash;
                rsp_last_q <= last_q;
            end
            if ((state_q == StResp) && last_q) begin
                locked_q <= 1'b0;
                rr_ptr_q <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (accept) begin
            bus.req_ready[win_idx] = 1'b1;
        end
        if (state_q == StResp) begin
            bus.rsp_valid[owner_q] = 1'b1;
        end
        bus.rsp_last    = rsp_last_q;
        bus.rsp_hash    = rsp_hash_q;
        bus.eng_valid   = (state_q == StIssue);
        bus.eng_mode    = mode_q;
        bus.eng_new_msg = new_msg_q;
        bus.eng_msg     = msg_q;
    end
endmodule

// File: doc/sha_engine_arbiter.md
# sha_engine_arbiter

Round-robin arbiter that shares one `sha_engine` among `NUM_REQ` independent hash clients. Message-level locking keeps the engine with one client from its first block to its last block, because the engine holds chaining state. The arbiter issues one block at a time to the engine as a single-cycle `valid` pulse, waits for completion, and returns the intermediate or final hash to the owning client. It sits between the client-side DMA/padding front-ends and the engine's slave port.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of clients (2..16).

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-client block request.
- `req_ready`  out  NUM_REQ  per-client accept; one-hot or zero.
- `req_mode`  in  NUM_REQ×3  per-client `sha::mode_t`.
- `req_new_msg`  in  NUM_REQ  block is the first block of a message.
- `req_last`  in  NUM_REQ  block is the last block of a message.
- `req_msg`  in  NUM_REQ×1024  per-client block, `sha::block_t` layout.
- `rsp_valid`  out  NUM_REQ  one-cycle pulse to the owner when a block completes.
- `rsp_last`  out  1  the completed block was the last block of its message.
- `rsp_hash`  out  512  `sha::hash_t`, held until the next response.
- `eng_valid`  out  1  engine request.
- `eng_ready`  in  1  engine ready.
- `eng_mode`  out  3  engine mode.
- `eng_new_msg`  out  1  engine new-message flag.
- `eng_msg`  out  1024  engine block.
- `eng_hash`  in  512  engine hash.

## Operation
- FSM states: ARB, ISSUE, BUSY, RESP.
- **ARB, unlocked:**
  - Eligible client i = `req_valid[i] & req_new_msg[i]`.
  - Winner is the first eligible index searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Requests with `req_new_msg=0` while unlocked are never eligible; they are held with `req_ready=0`.
- **ARB, locked:** only the owner is considered. It is accepted when `req_valid[owner]=1`, whatever its `req_new_msg` value.
- **Accept:**
  - In ARB with a winner, `req_ready[winner]=1` combinationally in the same cycle; the handshake completes that cycle.
  - `msg`, `new_msg` and `last` are latched into internal registers.
  - `mode` is latched only when unlocked. While locked, the latched message mode is reused and `req_mode` is ignored.
  - Owner is set to the winner and lock is set. Next state: ISSUE.
- **ISSUE:**
  - `eng_valid=1` for exactly one cycle.
  - `eng_mode`, `eng_new_msg` and `eng_msg` are driven from the latched registers; they are stable from ISSUE through RESP.
  - Next state: BUSY.
- **BUSY:**
  - `eng_valid=0`. `eng_ready` is 0 in the first BUSY cycle.
  - On the first cycle with `eng_ready=1`: capture `eng_hash` into `rsp_hash`, capture `rsp_last` from latched `last`, go to RESP.
- **RESP:**
  - `rsp_valid[owner]=1` for one cycle.
  - If latched `last=1`: clear lock and set `rr_ptr = (owner+1) mod NUM_REQ`.
  - Next state: ARB.
- No response is ever delivered to a client other than the owner. `rsp_valid` is one-hot or zero.

## Timing
- Reset values:
  - State ARB, unlocked, `rr_ptr=0`, owner=0.
  - `req_ready=0` outside ARB.
  - `rsp_valid=0`, `rsp_last=0`, `rsp_hash=0`.
  - `eng_valid=0`, `eng_mode=sha::sha1`, `eng_new_msg=0`, `eng_msg=0`.
- Accept in cycle t gives:
  - `eng_valid` in t+1.
  - `eng_ready` observed high in t+N+3.
  - `rsp_valid` in t+N+4.
  - N=64 for SHA-224/256; N=80 for SHA-1 and the SHA-384/512 family. So response latency is 68 or 84 cycles.
- Next accept is possible in the cycle after RESP.
  - Locked owner, steady stream: one block per N+5 cycles.
  - A new message starts in ARB the cycle after its predecessor's last RESP.
- Simultaneous events:
  - Requests from all clients in the same ARB cycle: exactly one is granted.
  - A request arriving during ISSUE/BUSY/RESP waits; inputs must be held stable until `req_ready`.
  - `req_new_msg=1` from the owner while locked: forwarded to the engine as given (engine reinitialises). The lock is unchanged.
- Reset mid-operation: `rst` in any state returns to reset values on the next edge; no response is issued. The engine must be reset in the same cycle by integration.
- `eng_valid` is never high for more than one consecutive cycle and never while the engine is busy.

## Test plan
- **Single client, SHA-256 "abc" padded block:** client 0 sends `new_msg=1`, `last=1`. Expected: `req_ready[0]` in the accept cycle, `eng_valid` one cycle later, `rsp_valid[0]` 68 cycles after accept, `rsp_hash` = ba7816bf…f20015ad, `rsp_last=1`.
- **Round-robin:** all 4 clients assert single-block SHA-1 at reset. Expected: grant order 0,1,2,3, responses spaced 85 cycles apart (84-cycle latency plus one ARB cycle), each to the correct client.
- **Lock:** client 2 sends a 2-block SHA-512 message while client 0 is waiting. Expected: both client-2 blocks are served before client 0. The second block has `eng_new_msg=0` and its mode comes from block 1, even though client 2 drives `req_mode=sha1`. Expected `rsp_last` = 0, then 1.
- **Ineligible request:** client 1 asserts `req_new_msg=0` while unlocked. Expected: `req_ready[1]` stays 0 for 200 cycles while client 3 is served normally.
- **Reset mid-BUSY:** assert `rst` 30 cycles after issue. Expected: all outputs reach reset values next cycle, no `rsp_valid` pulse, and the next request from client 1 (`rr_ptr=0` search) is granted normally.
- **Back-to-back owner re-request:** client 0 holds `req_valid` asserted across RESP. Expected: re-accept in the cycle after RESP, and `eng_valid` never high on two consecutive cycles.
